uart_tx_arbiter: RTL and testbench

//  Bus master sharing the UART transmit register among NumReq byte-stream requesters.

---
 rtl/uart_arb_pkg.sv | 25 ++
 rtl/rr_arbiter.sv | 42 ++++
 rtl/uart_tx_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared definitions for the UART transmit arbiter.
//   uart_arb_state_t  bus-master FSM states
//   UartTxOffset      byte offset of the UART TX register
//   UartStatusOffset  byte offset of the UART STATUS register
//   StatusTxFullBit   STATUS bit that reports a full TX FIFO
//   status_tx_full()  extracts the tx_full flag from a STATUS read
package uart_arb_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        STAT    = 3'd1,
        STAT_W  = 3'd2,
        WRITE   = 3'd3,
        WRITE_W = 3'd4
    } uart_arb_state_t;

    localparam logic [11:0] UartTxOffset     = 12'h004;
    localparam logic [11:0] UartStatusOffset = 12'h008;
    localparam int          StatusTxFullBit  = 1;

    function automatic logic status_tx_full(input logic [31:0] status);
        return status[StatusTxFullBit];
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational rotating-priority picker.
//   req    in   N     request vector
//   ptr    in   IdxW  index holding the highest priority this cycle
//   gnt    out  N     one-hot grant (first set bit at/after ptr, wrapping)
//   idx    out  IdxW  binary index of gnt
//   valid  out  1     at least one request present
module rr_arbiter #(
    parameter int N    = 2,
    parameter int IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req,
    input  logic [IdxW-1:0] ptr,
    output logic [N-1:0]    gnt,
    output logic [IdxW-1:0] idx,
    output logic            valid
);

    // Walk the requesters starting at ptr and take the first one that is set.
    always_comb begin : pick_blk
        int cand;
        cand  = 0;
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            cand = int'(ptr) + i;
            if (cand >= N) begin
                cand = cand - N;
            end else begin
                cand = cand;
            end
            if (!valid && req[cand]) begin
                valid     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = IdxW'(cand);
            end else begin
                valid = valid;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares the UART TX register among NumReq byte producers.
// Round-robin grant; each byte costs a STATUS poll (repeated while tx_full)
// followed by a TX write. All bus outputs and ack_o are registered.
// Ports:
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   req_i / data_i / last_i        per-requester byte handshake (ack_o pulses on write)
//   uart_req_o .. uart_wdata_o     single-cycle UART bus access
//   uart_rvalid_i, uart_rdata_i    UART response one cycle after each access
// Build option: define UART_ARB_LOCK_EN to keep a multi-byte message (ended by
// last_i) on one requester; otherwise last_i is ignored.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int          NumReq   = 2,
    parameter logic [31:0] UartBase = 32'h8000_1000
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NumReq-1:0]   req_i,
    input  logic [NumReq*8-1:0] data_i,
    input  logic [NumReq-1:0]   last_i,
    output logic [NumReq-1:0]   ack_o,
    output logic                uart_req_o,
    output logic [31:0]         uart_addr_o,
    output logic                uart_we_o,
    output logic [3:0]          uart_be_o,
    output logic [31:0]         uart_wdata_o,
    input  logic                uart_rvalid_i,
    input  logic [31:0]         uart_rdata_i
);

    localparam int          IdxW       = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam logic [31:0] StatusAddr = UartBase + {20'h00000, UartStatusOffset};
    localparam logic [31:0] TxAddr     = UartBase + {20'h00000, UartTxOffset};

    uart_arb_state_t   state_r, state_s;
    logic [IdxW-1:0]   grant_idx_r, grant_idx_s;
    logic [NumReq-1:0] grant_oh_r, grant_oh_s;
    logic [IdxW-1:0]   ptr_r;
    logic [NumReq-1:0] elig_s;
    logic [NumReq-1:0] arb_gnt_s;
    logic [IdxW-1:0]   arb_idx_s;
    logic              arb_valid_s;
    logic              wr_fire_s;

    logic              bus_req_s, bus_req_r;
    logic              bus_we_s, bus_we_r;
    logic [31:0]       bus_addr_s, bus_addr_r;
    logic [3:0]        bus_be_s, bus_be_r;
    logic [31:0]       bus_wdata_s, bus_wdata_r;
    logic [NumReq-1:0] ack_s, ack_r;

    rr_arbiter #(
        .N    (NumReq),
        .IdxW (IdxW)
    ) u_rr_arbiter (
        .req   (elig_s),
        .ptr   (ptr_r),
        .gnt   (arb_gnt_s),
        .idx   (arb_idx_s),
        .valid (arb_valid_s)
    );

`ifdef UART_ARB_LOCK_EN
    logic            lock_r;
    logic [IdxW-1:0] lock_idx_r;

    // While locked, only the lock owner may be granted; an owner that stops requesting frees the arbiter.
    always_comb begin
        if (lock_r && req_i[lock_idx_r]) begin
            elig_s             = '0;
            elig_s[lock_idx_r] = 1'b1;
        end else begin
            elig_s = req_i;
        end
    end

    // Lock set by a non-final byte, cleared by the final byte or by an idle owner.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_r     <= 1'b0;
            lock_idx_r <= '0;
        end else if (wr_fire_s) begin
            lock_r     <= ~last_i[grant_idx_r];
            lock_idx_r <= grant_idx_r;
        end else if ((state_r == IDLE) && lock_r && !req_i[lock_idx_r]) begin
            lock_r     <= 1'b0;
        end else begin
            lock_r     <= lock_r;
        end
    end
`else
    logic unused_last_s;
    assign unused_last_s = ^last_i;
    assign elig_s        = req_i;
`endif

    // Next state and next registered bus/ack values; outputs follow the state being entered.
    always_comb begin
        state_s     = state_r;
        grant_idx_s = grant_idx_r;
        grant_oh_s  = grant_oh_r;
        wr_fire_s   = 1'b0;
        bus_req_s   = 1'b0;
        bus_we_s    = 1'b0;
        bus_addr_s  = 32'h0000_0000;
        bus_be_s    = 4'b0000;
        bus_wdata_s = 32'h0000_0000;
        ack_s       = '0;
        case (state_r)
            IDLE: begin
                if (arb_valid_s) begin
                    grant_idx_s = arb_idx_s;
                    grant_oh_s  = arb_gnt_s;
                    state_s     = STAT;
                    bus_req_s   = 1'b1;
                    bus_addr_s  = StatusAddr;
                    bus_be_s    = 4'b0001;
                end else begin
                    state_s = IDLE;
                end
            end
            STAT: begin
                state_s = STAT_W;
            end
            STAT_W: begin
                if (!uart_rvalid_i) begin
                    state_s = STAT_W;
                end else if ((req_i & grant_oh_r) == '0) begin
                    // Requester withdrew: abandon the byte, pointer stays put.
                    state_s = IDLE;
                end else if (status_tx_full(uart_rdata_i)) begin
                    state_s    = STAT;
                    bus_req_s  = 1'b1;
                    bus_addr_s = StatusAddr;
                    bus_be_s   = 4'b0001;
                end else begin
                    state_s     = WRITE;
                    wr_fire_s   = 1'b1;
                    bus_req_s   = 1'b1;
                    bus_we_s    = 1'b1;
                    bus_addr_s  = TxAddr;
                    bus_be_s    = 4'b0001;
                    bus_wdata_s = {24'h000000, data_i[8*grant_idx_r +: 8]};
                    ack_s       = grant_oh_r;
                end
            end
            WRITE: begin
                state_s = WRITE_W;
            end
            WRITE_W: begin
                if (uart_rvalid_i) begin
                    state_s = IDLE;
                end else begin
                    state_s = WRITE_W;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, grant, round-robin pointer and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r     <= IDLE;
            grant_idx_r <= '0;
            grant_oh_r  <= '0;
            ptr_r       <= '0;
            bus_req_r   <= 1'b0;
            bus_we_r    <= 1'b0;
            bus_addr_r  <= 32'h0000_0000;
            bus_be_r    <= 4'b0000;
            bus_wdata_r <= 32'h0000_0000;
            ack_r       <= '0;
        end else begin
            state_r     <= state_s;
            grant_idx_r <= grant_idx_s;
            grant_oh_r  <= grant_oh_s;
            if (wr_fire_s) begin
                // Wrap explicitly so non-power-of-two NumReq (and NumReq=1) stay in range.
                ptr_r <= (grant_idx_r == IdxW'(NumReq - 1)) ? '0 : grant_idx_r + IdxW'(1);
            end else begin
                ptr_r <= ptr_r;
            end
            bus_req_r   <= bus_req_s;
            bus_we_r    <= bus_we_s;
            bus_addr_r  <= bus_addr_s;
            bus_be_r    <= bus_be_s;
            bus_wdata_r <= bus_wdata_s;
            ack_r       <= ack_s;
        end
    end

    assign uart_req_o   = bus_req_r;
    assign uart_we_o    = bus_we_r;
    assign uart_addr_o  = bus_addr_r;
    assign uart_be_o    = bus_be_r;
    assign uart_wdata_o = bus_wdata_r;
    assign ack_o        = ack_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (NumReq=2). Requesters are byte queues,
// the UART slave answers every access one cycle later and reports tx_full
// for as many status reads as full_cnt says.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_m = 2'b00;
    logic [1:0]  kill = 2'b00;
    logic [1:0]  req_i;
    logic [15:0] data_i = 16'h0000;
    logic [1:0]  last_i = 2'b00;
    logic [1:0]  ack_o;
    logic        uart_req_o, uart_we_o;
    logic [31:0] uart_addr_o, uart_wdata_o;
    logic [3:0]  uart_be_o;
    logic        model_rv = 1'b0;
    logic        stray_rv = 1'b0;
    logic        uart_rvalid_i;
    logic [31:0] uart_rdata_i = 32'h0;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int full_cnt = 0;
    logic [8:0] q0[$];
    logic [8:0] q1[$];
    int         ack_log[$];
    logic [7:0] wr_log[$];
    int          stat_cnt = 0;
    logic [31:0] stat_addr = 32'h0;
    logic [31:0] wr_addr = 32'h0;
    logic [3:0]  wr_be = 4'h0;
    int stat_cyc = 0, ack_cyc = 0, rise_cyc = 0;

    assign req_i         = req_m & ~kill;
    assign uart_rvalid_i = model_rv | stray_rv;

    uart_tx_arbiter #(.NumReq(2), .UartBase(32'h8000_1000)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .req_i         (req_i),
        .data_i        (data_i),
        .last_i        (last_i),
        .ack_o         (ack_o),
        .uart_req_o    (uart_req_o),
        .uart_addr_o   (uart_addr_o),
        .uart_we_o     (uart_we_o),
        .uart_be_o     (uart_be_o),
        .uart_wdata_o  (uart_wdata_o),
        .uart_rvalid_i (uart_rvalid_i),
        .uart_rdata_i  (uart_rdata_i)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // UART slave: one response per access, status full while full_cnt > 0.
    always @(posedge clk) begin
        model_rv <= uart_req_o;
        if (uart_req_o && !uart_we_o) begin
            if (full_cnt > 0) begin
                uart_rdata_i <= 32'h0000_0002;
                full_cnt--;
            end else begin
                uart_rdata_i <= 32'h0000_0000;
            end
        end
    end

    // Requesters: present queue head, advance on ack.
    always @(negedge clk) begin
        if (ack_o[0] && q0.size() > 0) void'(q0.pop_front());
        if (ack_o[1] && q1.size() > 0) void'(q1.pop_front());
        if (q0.size() > 0 && !req_m[0]) rise_cyc = cyc;
        if (q1.size() > 0 && !req_m[1]) rise_cyc = cyc;
        req_m[0]     = (q0.size() > 0);
        req_m[1]     = (q1.size() > 0);
        data_i[7:0]  = (q0.size() > 0) ? q0[0][7:0] : 8'h00;
        data_i[15:8] = (q1.size() > 0) ? q1[0][7:0] : 8'h00;
        last_i[0]    = (q0.size() > 0) ? q0[0][8] : 1'b0;
        last_i[1]    = (q1.size() > 0) ? q1[0][8] : 1'b0;
    end

    // Bus monitor.
    always @(negedge clk) begin
        if (rst_n) begin
            if (uart_req_o && !uart_we_o) begin
                stat_cnt++;
                stat_addr = uart_addr_o;
                stat_cyc  = cyc;
            end
            if (uart_req_o && uart_we_o) begin
                wr_log.push_back(uart_wdata_o[7:0]);
                wr_addr = uart_addr_o;
                wr_be   = uart_be_o;
            end
            if (ack_o != 2'b00) begin
                ack_log.push_back((ack_o == 2'b01) ? 0 : (ack_o == 2'b10) ? 1 : 99);
                ack_cyc = cyc;
                check_eq("ack_with_write", {31'h0, uart_req_o & uart_we_o}, 32'd1);
            end
        end
    end

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_acks(input int n, input int budget);
        int k;
        k = 0;
        while (ack_log.size() < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        #1;
        check_eq("ack_count", ack_log.size(), n);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_req"},   {31'h0, uart_req_o}, 32'd0);
        check_eq({tag, "_we"},    {31'h0, uart_we_o}, 32'd0);
        check_eq({tag, "_addr"},  uart_addr_o, 32'd0);
        check_eq({tag, "_be"},    {28'h0, uart_be_o}, 32'd0);
        check_eq({tag, "_wdata"}, uart_wdata_o, 32'd0);
        check_eq({tag, "_ack"},   {30'h0, ack_o}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int k;
        int exp_idx[4];
        logic [7:0] exp_byte[4];
        rst_n = 1'b0;
        run(3);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        run(1);

        // 1: single byte, FIFO not full
        q0.push_back({1'b1, 8'h41});
        wait_acks(1, 20);
        run(3);
        check_eq("t1_stat_addr", stat_addr, 32'h8000_1008);
        check_eq("t1_wr_addr", wr_addr, 32'h8000_1004);
        check_eq("t1_wr_data", {24'h0, wr_log[0]}, 32'h41);
        check_eq("t1_wr_be", {28'h0, wr_be}, 32'h1);
        check_eq("t1_ack_idx", ack_log[0], 0);
        check_eq("t1_stat_lat", stat_cyc - rise_cyc, 1);
        check_eq("t1_ack_lat", ack_cyc - rise_cyc, 3);
        check_eq("t1_stat_cnt", stat_cnt, 1);

        // 2: three full polls; req1 arrives mid-transaction, grant stays on req0
        full_cnt = 3;
        s0 = stat_cnt;
        q0.push_back({1'b1, 8'h55});
        run(2);
        q1.push_back({1'b1, 8'h66});
        wait_acks(3, 60);
        run(3);
        check_eq("t2_ack1", ack_log[1], 0);
        check_eq("t2_ack2", ack_log[2], 1);
        check_eq("t2_byte1", {24'h0, wr_log[1]}, 32'h55);
        check_eq("t2_byte2", {24'h0, wr_log[2]}, 32'h66);
        check_eq("t2_polls", stat_cnt - s0, 5);
        check_eq("t2_writes", wr_log.size(), 3);

        // 3: both busy, 4 bytes each -> strict alternation starting at req0
        for (int i = 0; i < 4; i++) begin
            q0.push_back({1'b1, 8'h10 + 8'(i)});
            q1.push_back({1'b1, 8'h20 + 8'(i)});
        end
        wait_acks(11, 200);
        run(3);
        for (int i = 0; i < 8; i++) begin
            check_eq($sformatf("t3_ack%0d", i), ack_log[3 + i], i % 2);
            check_eq($sformatf("t3_byte%0d", i), {24'h0, wr_log[3 + i]},
                     (i % 2 == 0) ? 32'h10 + i / 2 : 32'h20 + i / 2);
        end

        // 4: req0 withdraws while its status read is outstanding
        s0 = stat_cnt;
        q0.push_back({1'b1, 8'h77});
        q1.push_back({1'b1, 8'h88});
        k = 0;
        while (!(uart_req_o && !uart_we_o) && k < 20) begin
            @(negedge clk);
            k++;
        end
        kill[0] = 1'b1;
        wait_acks(12, 40);
        q0.delete();
        kill[0] = 1'b0;
        run(4);
        check_eq("t4_ack", ack_log[11], 1);
        check_eq("t4_byte", {24'h0, wr_log[11]}, 32'h88);
        check_eq("t4_writes", wr_log.size(), 12);
        check_eq("t4_polls", stat_cnt - s0, 2);

        // 5: req0 sends a 3-byte message while req1 waits
        q1.push_back({1'b1, 8'h99});
        q0.push_back({1'b0, 8'hA0});
        q0.push_back({1'b0, 8'hA1});
        q0.push_back({1'b1, 8'hA2});
`ifdef UART_ARB_LOCK_EN
        exp_idx  = '{0, 0, 0, 1};
        exp_byte = '{8'hA0, 8'hA1, 8'hA2, 8'h99};
`else
        exp_idx  = '{0, 1, 0, 0};
        exp_byte = '{8'hA0, 8'h99, 8'hA1, 8'hA2};
`endif
        wait_acks(16, 120);
        run(3);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("t5_ack%0d", i), ack_log[12 + i], exp_idx[i]);
            check_eq($sformatf("t5_byte%0d", i), {24'h0, wr_log[12 + i]}, {24'h0, exp_byte[i]});
        end

        // 6: reset during WRITE_W, then a stray rvalid while idle
        q0.push_back({1'b1, 8'hC3});
        wait_acks(17, 40);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("t6_rst");
        run(1);
        rst_n = 1'b1;
        run(1);
        stray_rv = 1'b1;
        run(1);
        stray_rv = 1'b0;
        s0 = stat_cnt;
        run(6);
        check_eq("t6_no_poll", stat_cnt, s0);
        check_eq("t6_no_ack", ack_log.size(), 17);
        check_eq("t6_req_low", {31'h0, uart_req_o}, 32'd0);
        q1.push_back({1'b1, 8'hD4});
        wait_acks(18, 20);
        run(3);
        check_eq("t6_stat_lat", stat_cyc - rise_cyc, 1);
        check_eq("t6_ack_lat", ack_cyc - rise_cyc, 3);
        check_eq("t6_ack", ack_log[17], 1);
        check_eq("t6_byte", {24'h0, wr_log[17]}, 32'hD4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
